// File: rtl/hazard_controller.sv
// hazard_controller
// -----------------
// Stall/flush sequencer for a 5-stage MIPS pipeline. From decoded ID- and
// EX-stage fields it detects load-use hazards, mult/div structural hazards and
// branch/jump redirects, and drives the PC, IF/ID and ID/EX enables. A small
// IDLE/BUSY machine tracks the multi-cycle mult/div unit. Saturating counters
// report the total stall cycles and IF/ID flushes.
//
// Parameters:
//   MD_LATENCY  mult/div busy cycles after issue (legal range 2..16)
//   CNT_W       width of the performance counters
//
// Ports:
//   clk              system clock, all state updates on the rising edge
//   rst              synchronous, active-high reset
//   id_rs, id_rt     source register fields of the instruction in ID
//   id_uses_rs/rt    ID instruction actually reads rs / rt
//   id_is_muldiv     ID instruction is mult/multu/div/divu
//   id_reads_hilo    ID instruction is mfhi/mflo
//   id_branch_taken  branch in ID resolved taken
//   id_jump          j/jal/jr in ID
//   ex_mem_read      instruction in EX is a load
//   ex_rt            destination register of the load in EX
//   pc_write         PC register enable
//   ifid_write       IF/ID register enable
//   ifid_flush       zero IF/ID on the next edge
//   idex_flush       insert a bubble into ID/EX on the next edge
//   md_start         one-cycle issue pulse to the mult/div unit
//   md_busy          high while the mult/div unit is busy
//   stall_cnt        total stall cycles (saturating)
//   flush_cnt        total IF/ID flushes (saturating)

module hazard_controller #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Countdown only needs to hold MD_LATENCY-1.
    localparam int unsigned MdCntW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MdCntW-1:0] MdCntInit = MdCntW'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CntMax    = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    state_e            state_q;
    logic [MdCntW-1:0] md_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic lu;
    logic md;
    logic stall;
    logic rs_match;
    logic rt_match;

    // ------------------------------------------------------------------
    // Hazard detection (combinational, zero-cycle latency)
    // ------------------------------------------------------------------
    always_comb begin
        rs_match = id_uses_rs && (id_rs == ex_rt);
        rt_match = id_uses_rt && (id_rt == ex_rt);
        // A load targeting $0 never produces a value worth waiting for.
        lu       = ex_mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);
        // In IDLE the HI/LO result is already valid, so mfhi/mflo proceed.
        md       = (state_q == StBusy) && (id_is_muldiv || id_reads_hilo);
        stall    = lu || md;
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        md_start   = 1'b0;
        if (rst) begin
            // Hold the front end and keep bubbles flowing while in reset.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            // Stall wins over a redirect; the branch re-resolves next cycle.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else begin
            ifid_flush = id_branch_taken || id_jump;
            md_start   = (state_q == StIdle) && id_is_muldiv;
        end
    end

    assign md_busy   = (state_q == StBusy);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // ------------------------------------------------------------------
    // Mult/div FSM and performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (md_start) begin
                        state_q  <= StBusy;
                        md_cnt_q <= MdCntInit;
                    end
                end
                StBusy: begin
                    if (md_cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        md_cnt_q <= md_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    md_cnt_q <= '0;
                end
            endcase

            // Load-use and mult/div stalls in the same cycle still count once.
            if (stall && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt_q != CntMax)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller. Each driven cycle pushes the
// expected outputs from a behavioural model onto a scoreboard queue; a monitor
// on the falling edge pops and compares them against the DUT.

module tb_hazard_controller;

    localparam int unsigned MdLat = 4;
    localparam int unsigned CntW  = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       is_muldiv;
        logic       reads_hilo;
        logic       br;
        logic       jmp;
        logic       ex_mem_read;
        logic [4:0] ex_rt;
    } stim_t;

    typedef struct packed {
        logic            pc_write;
        logic            ifid_write;
        logic            ifid_flush;
        logic            idex_flush;
        logic            md_start;
        logic            md_busy;
        logic [CntW-1:0] stall_cnt;
        logic [CntW-1:0] flush_cnt;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic            id_uses_rs;
    logic            id_uses_rt;
    logic            id_is_muldiv;
    logic            id_reads_hilo;
    logic            id_branch_taken;
    logic            id_jump;
    logic            ex_mem_read;
    logic [4:0]      ex_rt;
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_flush;
    logic            md_start;
    logic            md_busy;
    logic [CntW-1:0] stall_cnt;
    logic [CntW-1:0] flush_cnt;

    hazard_controller #(
        .MD_LATENCY(MdLat),
        .CNT_W     (CntW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_is_muldiv   (id_is_muldiv),
        .id_reads_hilo  (id_reads_hilo),
        .id_branch_taken(id_branch_taken),
        .id_jump        (id_jump),
        .ex_mem_read    (ex_mem_read),
        .ex_rt          (ex_rt),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .md_start       (md_start),
        .md_busy        (md_busy),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb_q[$];

    // Model state: cycles of busy remaining and the two counters.
    int unsigned m_busy_left = 0;
    int unsigned m_stall     = 0;
    int unsigned m_flush     = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the expectation, advance the model.
    task automatic step(input stim_t s);
        exp_t        e;
        logic        lu;
        logic        busy;
        logic        stall;
        int unsigned cmax;
        cmax = (1 << CntW) - 1;

        rst             = s.rst;
        id_rs           = s.id_rs;
        id_rt           = s.id_rt;
        id_uses_rs      = s.uses_rs;
        id_uses_rt      = s.uses_rt;
        id_is_muldiv    = s.is_muldiv;
        id_reads_hilo   = s.reads_hilo;
        id_branch_taken = s.br;
        id_jump         = s.jmp;
        ex_mem_read     = s.ex_mem_read;
        ex_rt           = s.ex_rt;

        lu    = s.ex_mem_read && (s.ex_rt != 0) &&
                ((s.uses_rs && s.id_rs == s.ex_rt) || (s.uses_rt && s.id_rt == s.ex_rt));
        busy  = (m_busy_left != 0);
        stall = lu || (busy && (s.is_muldiv || s.reads_hilo));

        e.md_busy   = busy;
        e.stall_cnt = CntW'(m_stall);
        e.flush_cnt = CntW'(m_flush);
        if (s.rst) begin
            e.pc_write   = 1'b0;
            e.ifid_write = 1'b0;
            e.ifid_flush = 1'b1;
            e.idex_flush = 1'b1;
            e.md_start   = 1'b0;
        end else begin
            e.pc_write   = !stall;
            e.ifid_write = !stall;
            e.idex_flush = stall;
            e.ifid_flush = !stall && (s.br || s.jmp);
            e.md_start   = !busy && s.is_muldiv && !stall;
        end
        sb_q.push_back(e);

        if (s.rst) begin
            m_busy_left = 0;
            m_stall     = 0;
            m_flush     = 0;
        end else begin
            if (e.md_start) m_busy_left = MdLat;
            else if (m_busy_left != 0) m_busy_left--;
            if (stall && m_stall != cmax) m_stall++;
            if (e.ifid_flush && m_flush != cmax) m_flush++;
        end

        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("pc_write",   32'(pc_write),   32'(e.pc_write));
            check_eq("ifid_write", 32'(ifid_write), 32'(e.ifid_write));
            check_eq("ifid_flush", 32'(ifid_flush), 32'(e.ifid_flush));
            check_eq("idex_flush", 32'(idex_flush), 32'(e.idex_flush));
            check_eq("md_start",   32'(md_start),   32'(e.md_start));
            check_eq("md_busy",    32'(md_busy),    32'(e.md_busy));
            check_eq("stall_cnt",  32'(stall_cnt),  32'(e.stall_cnt));
            check_eq("flush_cnt",  32'(flush_cnt),  32'(e.flush_cnt));
        end
    end

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rnd(input bit allow_rst);
        stim_t s;
        s.rst         = allow_rst && ($urandom_range(0, 39) == 0);
        s.id_rs       = 5'($urandom_range(0, 3));
        s.id_rt       = 5'($urandom_range(0, 3));
        s.uses_rs     = 1'($urandom);
        s.uses_rt     = 1'($urandom);
        s.is_muldiv   = ($urandom_range(0, 5) == 0);
        s.reads_hilo  = ($urandom_range(0, 4) == 0);
        s.br          = ($urandom_range(0, 4) == 0);
        s.jmp         = ($urandom_range(0, 7) == 0);
        s.ex_mem_read = 1'($urandom);
        s.ex_rt       = 5'($urandom_range(0, 3));
        return s;
    endfunction

    initial begin
        stim_t s;
        rst = 1'b1;
        {id_rs, id_rt, ex_rt} = '0;
        {id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo} = '0;
        {id_branch_taken, id_jump, ex_mem_read} = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with arbitrary inputs.
        for (int i = 0; i < 2; i++) begin
            s = rnd(1'b0);
            s.rst = 1'b1;
            s.is_muldiv = 1'b1;
            step(s);
        end
        step(nop());

        // Load-use on rs, then the same with ex_rt = $0.
        s = nop(); s.ex_mem_read = 1; s.ex_rt = 8; s.id_rs = 8; s.uses_rs = 1;
        step(s);
        step(nop());
        s.ex_rt = 0; s.id_rs = 0;
        step(s);
        // Load-use on rt; unused operand does not match.
        s = nop(); s.ex_mem_read = 1; s.ex_rt = 9; s.id_rt = 9; s.uses_rt = 1;
        step(s);
        s.uses_rt = 0;
        step(s);

        // Redirect alone, then redirect blocked by a load-use.
        s = nop(); s.br = 1;
        step(s);
        s.ex_mem_read = 1; s.ex_rt = 8; s.id_rs = 8; s.uses_rs = 1;
        step(s);
        s = nop(); s.jmp = 1;
        step(s);

        // Single muldiv issue, then mfhi held through BUSY.
        s = nop(); s.is_muldiv = 1;
        step(s);
        s = nop(); s.reads_hilo = 1;
        for (int i = 0; i < 6; i++) step(s);

        // Back-to-back muldiv held high, plus a load-use overlapping md.
        s = nop(); s.is_muldiv = 1;
        for (int i = 0; i < 14; i++) step(s);
        s.ex_mem_read = 1; s.ex_rt = 3; s.id_rs = 3; s.uses_rs = 1;
        step(s);
        for (int i = 0; i < 6; i++) step(nop());

        // Counter saturation.
        s = nop(); s.ex_mem_read = 1; s.ex_rt = 5; s.id_rt = 5; s.uses_rt = 1;
        for (int i = 0; i < 20; i++) step(s);
        s = nop(); s.br = 1;
        for (int i = 0; i < 18; i++) step(s);

        // Reset during the second BUSY cycle with a muldiv pending.
        s = nop(); s.is_muldiv = 1;
        step(s);
        step(nop());
        s.rst = 1;
        step(s);
        step(nop());
        step(nop());

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) step(rnd(1'b1));

        @(negedge clk);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline, fed by decoded ID- and EX-stage fields; drives the PC, IF/ID and ID/EX control enables.
- Detects load-use hazards and branch/jump redirects.
- Tracks the multi-cycle mult/div unit through a BUSY state machine.
- Keeps saturating stall and flush counters that the pipeline bench prints each cycle.

Parameters:
- MD_LATENCY, 4: mult/div busy cycles after issue; legal range 2..16.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_muldiv  in  1  ID instruction is mult/multu/div/divu.
- id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- id_branch_taken  in  1  branch in ID resolved taken.
- id_jump  in  1  j/jal/jr in ID.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination of the load in EX.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  zero IF/ID on the next edge.
- idex_flush  out  1  insert a bubble into ID/EX on the next edge.
- md_start  out  1  one-cycle issue pulse to the mult/div unit.
- md_busy  out  1  high while state is BUSY.
- stall_cnt  out  CNT_W  total stall cycles.
- flush_cnt  out  CNT_W  total IF/ID flushes.

Behaviour:
- Reset:
  - While rst=1, outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, md_start=0.
  - At the clock edge with rst=1: state←IDLE, md_cnt←0, stall_cnt←0, flush_cnt←0; hence md_busy=0 and stall_cnt=flush_cnt=0 after the edge.
  - rst while BUSY aborts the operation immediately; no md_start is issued in that cycle.
- Hazard outputs are combinational from current inputs and state. Zero-cycle latency.
- Load-use:
  - lu = ex_mem_read & (ex_rt≠0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- Mult/div structural hazard:
  - md = (state==BUSY) & (id_is_muldiv | id_reads_hilo).
  - In IDLE, mfhi/mflo never stall.
- stall = lu | md. When stall=1:
  - pc_write=0, ifid_write=0, idex_flush=1.
  - ifid_flush=0: stall has priority over redirect; the branch re-resolves next cycle.
  - md_start=0.
- No stall:
  - pc_write=1, ifid_write=1, idex_flush=0.
  - ifid_flush = id_branch_taken | id_jump.
- md_start = (state==IDLE) & id_is_muldiv & ~stall & ~rst.
- FSM (2 states):
  - IDLE→BUSY on md_start, with md_cnt←MD_LATENCY-1.
  - In BUSY: if md_cnt==0 then →IDLE, else md_cnt←md_cnt-1.
  - Net result: md_busy is high for exactly MD_LATENCY cycles after the issue edge.
  - A muldiv presented in the last BUSY cycle is stalled; it issues the following cycle from IDLE. No back-to-back overlap.
- Counters:
  - stall_cnt increments on every non-reset edge with stall=1.
  - flush_cnt increments on every non-reset edge with ifid_flush=1.
  - Both saturate at all-ones and never wrap.
- Register $0 as ex_rt never causes a stall.
- Simultaneous lu and md: one stall cycle per cycle, so stall_cnt increments by 1, not 2.

Test Plan:
- Reset: hold rst high for 2 cycles with arbitrary inputs -> pc_write=0, ifid_flush=1, idex_flush=1, md_busy=0, both counters=0 after release.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1, stall_cnt=1. Repeat with ex_rt=0 -> no stall, stall_cnt unchanged.
- Branch vs stall: id_branch_taken=1 with no hazard -> ifid_flush=1, flush_cnt=1. Same input together with a load-use match -> ifid_flush=0, pc_write=0, flush_cnt unchanged.
- Mult/div, MD_LATENCY=4: id_is_muldiv=1 for one cycle in IDLE -> md_start pulses once; md_busy high for exactly 4 cycles. id_reads_hilo=1 during BUSY -> stall each BUSY cycle (stall_cnt +4 if held throughout), proceeds on the first IDLE cycle.
- Back-to-back muldiv: hold id_is_muldiv=1 -> md_start pulses every 5 cycles, stalled in between; no md_start while md_busy=1.
- Saturation and reset mid-op: CNT_W=4, force 20 stall cycles -> stall_cnt holds 15. Assert rst in the 2nd BUSY cycle -> md_busy=0 next cycle, no spurious md_start.
